wb_commit_log: RTL and testbench

- Retirement trace buffer directly downstream of the pipeline's writeback outputs (wb_e / wb_a / wb_d).
- Captures every register-file commit, tags it with a sequence number, and queues it in a FIFO.
- Drains the queue over a valid/ready handshake to a trace sink (bench monitor, debug UART, lockstep checker).
- Never back-pressures the pipeline; overflow is counted, not stalled.

---
 rtl/wb_commit_log_pkg.sv | 16 +
 rtl/wb_commit_log_fifo.sv | 67 ++++++
 rtl/wb_commit_log.sv | 106 ++++++++++
 tb/tb_wb_commit_log.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_log_pkg.sv
// Shared types and constants for the writeback commit trace log.
package wb_commit_log_pkg;

   // Widest sequence number a record can carry; narrower SEQ_W settings
   // zero-extend into this field.
   localparam int unsigned SEQ_W_MAX = 16;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic [SEQ_W_MAX-1:0] seq;
      logic [4:0]           addr;
      logic [31:0]          data;
   } commit_rec_s;

endpackage

// File: rtl/wb_commit_log_fifo.sv
// Synchronous FIFO of commit records with an explicit occupancy counter.
module commit_fifo
   import wb_commit_log_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  commit_rec_s                din,
   output commit_rec_s                dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   commit_rec_s   mem_q [DEPTH];

   logic do_pop;
   logic do_push;

   assign full   = (level_q == LW'(DEPTH));
   assign empty  = (level_q == '0);
   assign level  = level_q;
   assign dout   = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Next-state for pointers and occupancy.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_d = level_q + LW'(1);
      else if (do_pop && !do_push) level_d = level_q - LW'(1);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are meaningless until covered by level.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/wb_commit_log.sv
// Retirement trace buffer: sequences register-file commits and queues them
// for a valid/ready trace sink without ever stalling the pipeline.
module wb_commit_log
   import wb_commit_log_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned SEQ_W   = 16,
   parameter int unsigned DROP_X0 = 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_e,
   input  logic [4:0]              wb_a,
   input  logic [31:0]             wb_d,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEQ_W-1:0]        out_seq,
   output logic [4:0]              out_addr,
   output logic [31:0]             out_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic                    overflow
);

   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   logic        commit;
   logic        fire;
   logic        drop;
   logic        fifo_full;
   logic        fifo_empty;
   commit_rec_s rec_in;
   commit_rec_s rec_out;

   assign commit = wb_e && !((DROP_X0 != 0) && (wb_a == REG_X0));
   assign fire   = out_valid && out_ready;
   assign drop   = commit && fifo_full && !fire;

   // Record for the current commit; seq is zero-extended into the shared field.
   always_comb begin
      rec_in      = '0;
      rec_in.seq  = SEQ_W_MAX'(seq_q);
      rec_in.addr = wb_a;
      rec_in.data = wb_d;
   end

   commit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (commit),
      .pop   (fire),
      .din   (rec_in),
      .dout  (rec_out),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head fields are forced to zero while nothing is queued.
   always_comb begin
      out_valid = !fifo_empty;
      out_seq   = '0;
      out_addr  = '0;
      out_data  = '0;
      if (out_valid) begin
         out_seq  = rec_out.seq[SEQ_W-1:0];
         out_addr = rec_out.addr;
         out_data = rec_out.data;
      end
   end

   // Sequence, drop counter and sticky overflow next-state; dropped commits
   // still consume a sequence number so the sink can see the gap.
   always_comb begin
      seq_d      = seq_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (commit) seq_d = seq_q + SEQ_W'(1);
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seq_q      <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         seq_q      <= seq_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_commit_log.sv
// Scoreboard bench for wb_commit_log: a default instance plus a SEQ_W=4
// instance for the sequence wrap.
module tb_wb_commit_log;

   typedef struct {
      logic [15:0] seq;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        wb_e = 1'b0;
   logic [4:0]  wb_a = '0;
   logic [31:0] wb_d = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_seq;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic [3:0]  level;
   logic [7:0]  drop_cnt;
   logic        overflow;

   logic        wb_e4 = 1'b0;
   logic [4:0]  wb_a4 = '0;
   logic [31:0] wb_d4 = '0;
   logic        out_ready4 = 1'b0;
   logic        out_valid4;
   logic [3:0]  out_seq4;
   logic [4:0]  out_addr4;
   logic [31:0] out_data4;
   logic [3:0]  level4;
   logic [7:0]  drop_cnt4;
   logic        overflow4;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t        sb[$];
   exp_t        e;
   logic [15:0] mseq = '0;
   int          mdrop = 0;
   logic        movf = 1'b0;

   logic [3:0]  sb4[$];
   logic [3:0]  e4;
   logic [3:0]  mseq4 = '0;
   int          cnt4 = 0;

   always #5 clk = ~clk;

   wb_commit_log dut (
      .clk       (clk),
      .reset     (reset),
      .wb_e      (wb_e),
      .wb_a      (wb_a),
      .wb_d      (wb_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_seq   (out_seq),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .level     (level),
      .drop_cnt  (drop_cnt),
      .overflow  (overflow)
   );

   wb_commit_log #(
      .DEPTH   (8),
      .SEQ_W   (4),
      .DROP_X0 (1),
      .CNT_W   (8)
   ) dut4 (
      .clk       (clk),
      .reset     (reset),
      .wb_e      (wb_e4),
      .wb_a      (wb_a4),
      .wb_d      (wb_d4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_seq   (out_seq4),
      .out_addr  (out_addr4),
      .out_data  (out_data4),
      .level     (level4),
      .drop_cnt  (drop_cnt4),
      .overflow  (overflow4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [4:0] a, input logic [31:0] d);
      wb_e = 1'b1;
      wb_a = a;
      wb_d = d;
      cyc();
   endtask

   task automatic do_reset();
      wb_e = 1'b0;
      out_ready = 1'b0;
      reset = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid; i++) cyc();
      out_ready = 1'b0;
      check("drain_done", out_valid, 1'b0);
   endtask

   // Reference model for the default instance, evaluated between edges.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         mseq = '0;
         mdrop = 0;
         movf = 1'b0;
      end else begin
         check("valid", out_valid, sb.size() != 0);
         check("level", level, sb.size());
         check("drop_cnt", drop_cnt, mdrop);
         check("overflow", overflow, movf);
         if (out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("head_seq", out_seq, e.seq);
            check("head_addr", out_addr, e.addr);
            check("head_data", out_data, e.data);
         end
         if (wb_e && wb_a != 5'd0) begin
            if (sb.size() < 8) begin
               sb.push_back('{seq: mseq, addr: wb_a, data: wb_d});
            end else begin
               if (mdrop != 255) mdrop++;
               movf = 1'b1;
            end
            mseq = mseq + 16'd1;
         end
      end
   end

   // Reference model for the SEQ_W=4 instance.
   always @(negedge clk) begin
      if (!reset) begin
         sb4.delete();
         mseq4 = '0;
      end else begin
         if (out_valid4 && out_ready4) begin
            if (sb4.size() == 0) begin
               check("seq4_spurious", 1'b1, 1'b0);
            end else begin
               e4 = sb4.pop_front();
               check("seq4", out_seq4, e4);
               cnt4++;
            end
         end
         if (wb_e4 && wb_a4 != 5'd0) begin
            sb4.push_back(mseq4);
            mseq4 = mseq4 + 4'd1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #1;
      do_reset();
      check("rst_valid", out_valid, 1'b0);
      check("rst_level", level, 4'd0);
      check("rst_seq", out_seq, 16'd0);
      check("rst_addr", out_addr, 5'd0);
      check("rst_data", out_data, 32'd0);

      // Single commit, held, then one ready pulse
      push1(5'd5, 32'hDEADBEEF);
      wb_e = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("single_valid", out_valid, 1'b1);
         check("single_seq", out_seq, 16'd0);
         check("single_addr", out_addr, 5'd5);
         check("single_data", out_data, 32'hDEADBEEF);
         check("single_level", level, 4'd1);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("single_popped", out_valid, 1'b0);

      // x0 filter
      do_reset();
      push1(5'd0, 32'h10);
      push1(5'd1, 32'h11);
      push1(5'd0, 32'h12);
      push1(5'd2, 32'h13);
      wb_e = 1'b0;
      check("x0_level", level, 4'd2);
      check("x0_first_seq", out_seq, 16'd0);
      check("x0_first_addr", out_addr, 5'd1);
      drain();

      // Overflow
      do_reset();
      for (int i = 0; i < 10; i++) push1(5'd1, i);
      wb_e = 1'b0;
      check("ovf_level", level, 4'd8);
      check("ovf_drop", drop_cnt, 8'd2);
      check("ovf_flag", overflow, 1'b1);
      drain();
      check("ovf_sticky", overflow, 1'b1);
      push1(5'd1, 32'd10);
      wb_e = 1'b0;
      check("ovf_next_seq", out_seq, 16'd10);
      drain();

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 8; i++) push1(5'd3, i);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push1(5'd3, 100 + i);
         check("full_level", level, 4'd8);
      end
      wb_e = 1'b0;
      check("full_drop", drop_cnt, 8'd0);
      check("full_ovf", overflow, 1'b0);
      drain();

      // Async reset mid-drain
      do_reset();
      for (int i = 0; i < 4; i++) push1(5'd4, 32'h40 + i);
      wb_e = 1'b0;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("mid_level", level, 4'd3);
      #2;
      reset = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_level", level, 4'd0);
      check("arst_drop", drop_cnt, 8'd0);
      cyc();
      reset = 1'b1;
      push1(5'd7, 32'h77);
      wb_e = 1'b0;
      check("arst_seq", out_seq, 16'd0);
      check("arst_addr", out_addr, 5'd7);
      drain();

      // Sequence wrap on the SEQ_W=4 instance
      out_ready4 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         wb_e4 = 1'b1;
         wb_a4 = 5'd3;
         wb_d4 = i;
         cyc();
      end
      wb_e4 = 1'b0;
      repeat (4) cyc();
      check("wrap_count", cnt4, 18);
      check("wrap_valid", out_valid4, 1'b0);
      check("wrap_drop", drop_cnt4, 8'd0);

      check("sb_empty", sb.size(), 0);
      check("sb4_empty", sb4.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
